// File: rtl/onehot_seq_pkg.sv
// Shared definitions for the one-hot code sequencer.
// Contents:
//   state_t              - sequencer state encoding (IDLE, HOLD, SCAN, DONE)
//   DEFAULT_WIDTH        - default number of one-hot lines
//   DEFAULT_HOLD_CYCLES  - default cycles each code is held
package onehot_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH       = 4;
  localparam int DEFAULT_HOLD_CYCLES = 2;

endpackage

// File: rtl/onehot_hold_counter.sv
// Hold counter shared by the HOLD and SCAN states of the sequencer.
// Counts the cycles the current code has been on the bus, starting at 0 in
// the first cycle a code is shown. tc flags the last cycle of the hold.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset (count -> 0)
//   clear in   restart the count at 0 (code change or not holding)
//   en    in   advance the count by one
//   tc    out  count has reached HOLD_CYCLES-1
module onehot_hold_counter #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(HOLD_CYCLES - 1));

endmodule

// File: rtl/onehot_code_sequencer.sv
// Registered upstream driver for a 4-bit-style one-hot select consumer.
// Turns a binary request into a held one-hot code, or scans through every
// one-hot position, holding each for HOLD_CYCLES cycles.
// Build option: define ONEHOT_SCAN_WRAP_EN to make the scan wrap from the
// MSB straight back to the LSB forever (scan_done pulses on every wrap);
// when undefined the scan runs one pass and finishes through DONE.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   mode       in   0 = single request, 1 = auto-scan (used in IDLE only)
//   start      in   scan launch pulse (mode=1)
//   abort      in   synchronous abort of any operation
//   req_valid  in   single-request valid (mode=0)
//   req_idx    in   index of the bit to assert
//   req_ready  out  high in IDLE with mode=0
//   onehot_out out  registered one-hot code, zero when inactive
//   code_valid out  high exactly while onehot_out is non-zero
//   busy       out  high in any state other than IDLE
//   scan_done  out  one-cycle pulse at the end of a scan pass
module onehot_code_sequencer
  import onehot_seq_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int IDXW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             start,
  input  logic             abort,
  input  logic             req_valid,
  input  logic [IDXW-1:0]  req_idx,
  output logic             req_ready,
  output logic [WIDTH-1:0] onehot_out,
  output logic             code_valid,
  output logic             busy,
  output logic             scan_done
);

  localparam logic [IDXW:0] WIDTH_L = (IDXW + 1)'(WIDTH);

  state_t state;
  logic   hold_tc;
  logic   holding;
  logic   cnt_clear;

  // The counter only runs while a code is on the bus; any code change,
  // abort or non-holding state restarts it from zero.
  assign holding   = (state == HOLD) || (state == SCAN);
  assign cnt_clear = !holding || abort || hold_tc;

  onehot_hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(cnt_clear),
    .en   (holding),
    .tc   (hold_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      onehot_out <= '0;
      code_valid <= 1'b0;
      busy       <= 1'b0;
      scan_done  <= 1'b0;
      req_ready  <= !mode;
    end else if (state != IDLE && abort) begin
      // Abort discards the operation outright: no scan_done pulse.
      state      <= IDLE;
      onehot_out <= '0;
      code_valid <= 1'b0;
      busy       <= 1'b0;
      scan_done  <= 1'b0;
      req_ready  <= !mode;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= !mode;
          if (!abort && !mode && req_valid && req_ready) begin
            // Out-of-range indices are consumed without producing a code.
            if ({1'b0, req_idx} < WIDTH_L) begin
              state      <= HOLD;
              onehot_out <= WIDTH'(1) << req_idx;
              code_valid <= 1'b1;
              busy       <= 1'b1;
              req_ready  <= 1'b0;
            end
          end else if (!abort && mode && start) begin
            state      <= SCAN;
            onehot_out <= WIDTH'(1);
            code_valid <= 1'b1;
            busy       <= 1'b1;
            req_ready  <= 1'b0;
          end
        end
        HOLD: begin
          if (hold_tc) begin
            state      <= IDLE;
            onehot_out <= '0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= !mode;
          end
        end
        SCAN: begin
          if (hold_tc) begin
            if (onehot_out[WIDTH-1]) begin
`ifdef ONEHOT_SCAN_WRAP_EN
              onehot_out <= WIDTH'(1);
              scan_done  <= 1'b1;
`else
              state      <= DONE;
              onehot_out <= '0;
              code_valid <= 1'b0;
              scan_done  <= 1'b1;
`endif
            end else begin
              onehot_out <= onehot_out << 1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= !mode;
        end
        default: begin
          state      <= IDLE;
          onehot_out <= '0;
          code_valid <= 1'b0;
          busy       <= 1'b0;
          req_ready  <= !mode;
        end
      endcase
    end
  end

endmodule
